// File: rtl/fpro_bus_arbiter_if.sv
// Bundle of both master request ports and the shared FPro bus, seen from
// the arbiter (slave) and from the masters/bus model side (master).
interface fpro_bus_arbiter_if #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 32
);
    logic              m0_req,     m1_req;
    logic              m0_wr,      m1_wr;
    logic              m0_video,   m1_video;
    logic [ADDR_W-1:0] m0_addr,    m1_addr;
    logic [DATA_W-1:0] m0_wr_data, m1_wr_data;
    logic              m0_ack,     m1_ack;
    logic [DATA_W-1:0] m0_rd_data, m1_rd_data;
    logic              fp_mmio_cs, fp_video_cs;
    logic              fp_wr,      fp_rd;
    logic [ADDR_W-1:0] fp_addr;
    logic [DATA_W-1:0] fp_wr_data;
    logic [DATA_W-1:0] fp_rd_data;

    modport slave (
        input  m0_req, m1_req, m0_wr, m1_wr, m0_video, m1_video,
        input  m0_addr, m1_addr, m0_wr_data, m1_wr_data, fp_rd_data,
        output m0_ack, m1_ack, m0_rd_data, m1_rd_data,
        output fp_mmio_cs, fp_video_cs, fp_wr, fp_rd, fp_addr, fp_wr_data
    );

    modport master (
        output m0_req, m1_req, m0_wr, m1_wr, m0_video, m1_video,
        output m0_addr, m1_addr, m0_wr_data, m1_wr_data, fp_rd_data,
        input  m0_ack, m1_ack, m0_rd_data, m1_rd_data,
        input  fp_mmio_cs, fp_video_cs, fp_wr, fp_rd, fp_addr, fp_wr_data
    );
endinterface

// File: rtl/fpro_bus_arbiter.sv
// Round-robin arbiter sharing one FPro bus between two masters; each grant
// runs a single registered bus cycle (XFER) followed by a one-cycle ack.
module fpro_bus_arbiter #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    fpro_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, XFER, ACK} state_t;

    state_t            state_q;
    logic              last_grant_q;
    logic              wr_q, video_q;
    logic              m0_ack_q, m1_ack_q;
    logic [DATA_W-1:0] m0_rd_data_q, m1_rd_data_q;
    logic              fp_mmio_cs_q, fp_video_cs_q, fp_wr_q, fp_rd_q;
    logic [ADDR_W-1:0] fp_addr_q;
    logic [DATA_W-1:0] fp_wr_data_q;

    logic              req_any_d, grant_d, wr_d, video_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wr_data_d;
    logic [DATA_W-1:0] rd_capture_d;

    // On a tie the master that did not win last time gets the bus.
    always_comb begin
        req_any_d    = bus.m0_req | bus.m1_req;
        grant_d      = bus.m1_req & (~bus.m0_req | ~last_grant_q);
        wr_d         = grant_d ? bus.m1_wr      : bus.m0_wr;
        video_d      = grant_d ? bus.m1_video   : bus.m0_video;
        addr_d       = grant_d ? bus.m1_addr    : bus.m0_addr;
        wr_data_d    = grant_d ? bus.m1_wr_data : bus.m0_wr_data;
        rd_capture_d = video_q ? '0 : bus.fp_rd_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            wr_q          <= 1'b0;
            video_q       <= 1'b0;
            m0_ack_q      <= 1'b0;
            m1_ack_q      <= 1'b0;
            m0_rd_data_q  <= '0;
            m1_rd_data_q  <= '0;
            fp_mmio_cs_q  <= 1'b0;
            fp_video_cs_q <= 1'b0;
            fp_wr_q       <= 1'b0;
            fp_rd_q       <= 1'b0;
            fp_addr_q     <= '0;
            fp_wr_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_any_d) begin
                        last_grant_q  <= grant_d;
                        wr_q          <= wr_d;
                        video_q       <= video_d;
                        // Video is write-only: a video read drives no cs/strobe.
                        fp_mmio_cs_q  <= ~video_d;
                        fp_video_cs_q <= video_d & wr_d;
                        fp_wr_q       <= wr_d;
                        fp_rd_q       <= ~wr_d & ~video_d;
                        fp_addr_q     <= addr_d;
                        fp_wr_data_q  <= wr_data_d;
                        state_q       <= XFER;
                    end
                end
                XFER: begin
                    if (!wr_q) begin
                        if (last_grant_q) m1_rd_data_q <= rd_capture_d;
                        else              m0_rd_data_q <= rd_capture_d;
                    end
                    m0_ack_q      <= ~last_grant_q;
                    m1_ack_q      <= last_grant_q;
                    fp_mmio_cs_q  <= 1'b0;
                    fp_video_cs_q <= 1'b0;
                    fp_wr_q       <= 1'b0;
                    fp_rd_q       <= 1'b0;
                    fp_addr_q     <= '0;
                    fp_wr_data_q  <= '0;
                    state_q       <= ACK;
                end
                ACK: begin
                    m0_ack_q <= 1'b0;
                    m1_ack_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    m0_ack_q <= 1'b0;
                    m1_ack_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign bus.m0_ack      = m0_ack_q;
    assign bus.m1_ack      = m1_ack_q;
    assign bus.m0_rd_data  = m0_rd_data_q;
    assign bus.m1_rd_data  = m1_rd_data_q;
    assign bus.fp_mmio_cs  = fp_mmio_cs_q;
    assign bus.fp_video_cs = fp_video_cs_q;
    assign bus.fp_wr       = fp_wr_q;
    assign bus.fp_rd       = fp_rd_q;
    assign bus.fp_addr     = fp_addr_q;
    assign bus.fp_wr_data  = fp_wr_data_q;
endmodule

// File: tb/tb_fpro_bus_arbiter.sv
// Self-checking bench for fpro_bus_arbiter: per-scenario tasks plus an
// ack-driven scoreboard holding the expected grant order and rd_data values.
module tb_fpro_bus_arbiter;
    localparam int ADDR_W = 21;
    localparam int DATA_W = 32;
    localparam int VEC_W  = 4 + ADDR_W + DATA_W;

    typedef struct {
        int                m;
        logic [DATA_W-1:0] rd0;
        logic [DATA_W-1:0] rd1;
    } exp_t;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    exp_t exp_q[$];
    logic [DATA_W-1:0] sh0, sh1;

    fpro_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fpro_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] rd_model(input logic [ADDR_W-1:0] a);
        if (a == 21'h00100) return 32'hDEAD_BEEF;
        return 32'hC0DE_0000 ^ {{(DATA_W-ADDR_W){1'b0}}, a};
    endfunction

    // Subsystem read data is combinational from the current address.
    always_comb bus.fp_rd_data = rd_model(bus.fp_addr);

    function automatic logic [VEC_W-1:0] bus_vec();
        return {bus.fp_mmio_cs, bus.fp_video_cs, bus.fp_wr, bus.fp_rd,
                bus.fp_addr, bus.fp_wr_data};
    endfunction

    function automatic logic [VEC_W-1:0] exp_vec(input logic wr, input logic video,
                                                 input logic [ADDR_W-1:0] a,
                                                 input logic [DATA_W-1:0] d);
        return {~video, video & wr, wr, ~wr & ~video, a, d};
    endfunction

    function automatic void push_exp(input int m, input logic wr, input logic video,
                                     input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        exp_t e;
        v = video ? '0 : rd_model(a);
        if (!wr) begin
            if (m == 1) sh1 = v;
            else        sh0 = v;
        end
        e.m = m; e.rd0 = sh0; e.rd1 = sh1;
        exp_q.push_back(e);
    endfunction

    task automatic set_m(input int m, input logic req, input logic wr, input logic video,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (m == 1) begin
            bus.m1_req = req; bus.m1_wr = wr; bus.m1_video = video;
            bus.m1_addr = a;  bus.m1_wr_data = d;
        end else begin
            bus.m0_req = req; bus.m0_wr = wr; bus.m0_video = video;
            bus.m0_addr = a;  bus.m0_wr_data = d;
        end
    endtask

    // Scoreboard: every ack pops the next expected grant and rd_data pair.
    always @(negedge clk) begin
        if (bus.m0_ack === 1'b1 || bus.m1_ack === 1'b1) begin
            checks++;
            if (bus.m0_ack === 1'b1 && bus.m1_ack === 1'b1) begin
                errors++;
                $display("FAIL ack_both: m0_ack=1 m1_ack=1 required one-hot");
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: m0_ack=%0b m1_ack=%0b with no pending transaction",
                         bus.m0_ack, bus.m1_ack);
            end else begin
                exp_t e;
                int   am;
                e  = exp_q.pop_front();
                am = (bus.m1_ack === 1'b1) ? 1 : 0;
                if (am !== e.m || bus.m0_rd_data !== e.rd0 || bus.m1_rd_data !== e.rd1) begin
                    errors++;
                    $display("FAIL sb_ack: got master %0d rd0=%h rd1=%h required master %0d rd0=%h rd1=%h",
                             am, bus.m0_rd_data, bus.m1_rd_data, e.m, e.rd0, e.rd1);
                end
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        sh0 = '0; sh1 = '0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One isolated transaction: XFER one cycle after sampling, ack the next.
    task automatic do_txn(input int m, input logic wr, input logic video,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        logic ack;
        set_m(m, 1'b1, wr, video, a, d);
        push_exp(m, wr, video, a);
        @(negedge clk);
        checks++;
        if (bus_vec() !== exp_vec(wr, video, a, d)) begin
            errors++;
            $display("FAIL txn_xfer m%0d: bus=%h required %h", m, bus_vec(), exp_vec(wr, video, a, d));
        end
        @(negedge clk);
        ack = (m == 1) ? bus.m1_ack : bus.m0_ack;
        checks++;
        if (ack !== 1'b1 || bus_vec() !== '0) begin
            errors++;
            $display("FAIL txn_ack m%0d: ack=%b bus=%h required ack=1 bus=0", m, ack, bus_vec());
        end
        set_m(m, 1'b0, wr, video, a, d);
        @(negedge clk);
        checks++;
        if (bus.m0_ack !== 1'b0 || bus.m1_ack !== 1'b0 || bus_vec() !== '0) begin
            errors++;
            $display("FAIL txn_idle m%0d: acks=%b%b bus=%h required all 0",
                     m, bus.m0_ack, bus.m1_ack, bus_vec());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus_vec() !== '0 || bus.m0_ack !== 1'b0 || bus.m1_ack !== 1'b0 ||
            bus.m0_rd_data !== '0 || bus.m1_rd_data !== '0) begin
            errors++;
            $display("FAIL reset_state: bus=%h acks=%b%b rd0=%h rd1=%h required all 0",
                     bus_vec(), bus.m0_ack, bus.m1_ack, bus.m0_rd_data, bus.m1_rd_data);
        end
        sh0 = '0; sh1 = '0;
        @(negedge clk);
        reset_n = 1'b1;
        do_txn(0, 1'b1, 1'b0, 21'h00040, 32'h0000_00AA);
    endtask

    task automatic test_single_read();
        do_txn(1, 1'b0, 1'b0, 21'h00100, 32'h0);
        repeat (2) @(negedge clk);
        checks++;
        if (bus.m1_rd_data !== 32'hDEAD_BEEF || bus.m0_rd_data !== 32'h0) begin
            errors++;
            $display("FAIL read_hold: rd1=%h rd0=%h required DEADBEEF 00000000",
                     bus.m1_rd_data, bus.m0_rd_data);
        end
    endtask

    task automatic test_video();
        do_txn(0, 1'b1, 1'b1, 21'h00123, 32'h5555_AAAA);
        do_txn(1, 1'b0, 1'b1, 21'h00200, 32'h0);
    endtask

    task automatic test_round_robin();
        logic [VEC_W-1:0] v0, v1, ve;
        apply_reset();
        v0 = exp_vec(1'b1, 1'b0, 21'h00010, 32'h0000_0011);
        v1 = exp_vec(1'b0, 1'b0, 21'h00020, 32'h0);
        @(negedge clk);
        set_m(0, 1'b1, 1'b1, 1'b0, 21'h00010, 32'h0000_0011);
        set_m(1, 1'b1, 1'b0, 1'b0, 21'h00020, 32'h0);
        push_exp(0, 1'b1, 1'b0, 21'h00010);
        push_exp(1, 1'b0, 1'b0, 21'h00020);
        push_exp(0, 1'b1, 1'b0, 21'h00010);
        for (int c = 1; c <= 9; c++) begin
            int ms;
            logic ack;
            @(negedge clk);
            ms  = ((c - 1) / 3) % 2;
            ve  = (ms == 1) ? v1 : v0;
            ack = (ms == 1) ? bus.m1_ack : bus.m0_ack;
            checks++;
            if (c % 3 == 1) begin
                if (bus_vec() !== ve) begin
                    errors++;
                    $display("FAIL rr_xfer c%0d: bus=%h required %h (m%0d)", c, bus_vec(), ve, ms);
                end
            end else if (c % 3 == 2) begin
                if (ack !== 1'b1 || bus_vec() !== '0) begin
                    errors++;
                    $display("FAIL rr_ack c%0d: m%0d ack=%b bus=%h required ack=1 bus=0",
                             c, ms, ack, bus_vec());
                end
            end else if (bus_vec() !== '0 || bus.m0_ack !== 1'b0 || bus.m1_ack !== 1'b0) begin
                errors++;
                $display("FAIL rr_idle c%0d: bus=%h acks=%b%b required all 0",
                         c, bus_vec(), bus.m0_ack, bus.m1_ack);
            end
            if (c == 8) begin
                bus.m0_req = 1'b0;
                bus.m1_req = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || bus_vec() !== '0) begin
            errors++;
            $display("FAIL rr_done: pending=%0d bus=%h required 0 pending, idle bus",
                     exp_q.size(), bus_vec());
        end
    endtask

    task automatic test_reset_mid();
        logic [VEC_W-1:0] vm0, vm1;
        vm0 = exp_vec(1'b1, 1'b0, 21'h00300, 32'h0000_0033);
        vm1 = exp_vec(1'b0, 1'b0, 21'h00100, 32'h0);
        @(negedge clk);
        set_m(0, 1'b1, 1'b1, 1'b0, 21'h00300, 32'h0000_0033);
        @(negedge clk);
        checks++;
        if (bus_vec() !== vm0) begin
            errors++;
            $display("FAIL mid_xfer: bus=%h required %h", bus_vec(), vm0);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (bus_vec() !== '0 || bus.m0_ack !== 1'b0 || bus.m1_ack !== 1'b0 ||
            bus.m0_rd_data !== '0 || bus.m1_rd_data !== '0) begin
            errors++;
            $display("FAIL mid_abort: bus=%h acks=%b%b rd0=%h rd1=%h required all 0",
                     bus_vec(), bus.m0_ack, bus.m1_ack, bus.m0_rd_data, bus.m1_rd_data);
        end
        sh0 = '0; sh1 = '0;
        @(negedge clk);
        reset_n = 1'b1;
        set_m(1, 1'b1, 1'b0, 1'b0, 21'h00100, 32'h0);
        push_exp(0, 1'b1, 1'b0, 21'h00300);
        push_exp(1, 1'b0, 1'b0, 21'h00100);
        @(negedge clk);
        checks++;
        if (bus_vec() !== vm0) begin
            errors++;
            $display("FAIL mid_prio: bus=%h required %h (m0 first)", bus_vec(), vm0);
        end
        @(negedge clk);
        checks++;
        if (bus.m0_ack !== 1'b1) begin
            errors++;
            $display("FAIL mid_ack0: m0_ack=%b required 1", bus.m0_ack);
        end
        bus.m0_req = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus_vec() !== vm1) begin
            errors++;
            $display("FAIL mid_m1_xfer: bus=%h required %h", bus_vec(), vm1);
        end
        @(negedge clk);
        checks++;
        if (bus.m1_ack !== 1'b1) begin
            errors++;
            $display("FAIL mid_ack1: m1_ack=%b required 1", bus.m1_ack);
        end
        bus.m1_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_req_drop();
        logic [VEC_W-1:0] vx;
        vx = exp_vec(1'b1, 1'b0, 21'h00400, 32'h0000_0044);
        @(negedge clk);
        set_m(1, 1'b1, 1'b1, 1'b0, 21'h00400, 32'h0000_0044);
        push_exp(1, 1'b1, 1'b0, 21'h00400);
        @(negedge clk);
        checks++;
        if (bus_vec() !== vx) begin
            errors++;
            $display("FAIL drop_xfer: bus=%h required %h", bus_vec(), vx);
        end
        bus.m1_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.m1_ack !== 1'b1) begin
            errors++;
            $display("FAIL drop_ack: m1_ack=%b required 1", bus.m1_ack);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (bus_vec() !== '0 || bus.m0_ack !== 1'b0 || bus.m1_ack !== 1'b0) begin
                errors++;
                $display("FAIL drop_quiet c%0d: bus=%h acks=%b%b required all 0",
                         c, bus_vec(), bus.m0_ack, bus.m1_ack);
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        sh0     = '0;
        sh1     = '0;
        reset_n = 1'b0;
        set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
        set_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);
        test_reset();
        test_single_read();
        test_video();
        test_round_robin();
        test_reset_mid();
        test_req_drop();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d expected acks never seen, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
